fixed_point_divider: RTL
========================

Name: fixed_point_divider

Overview:
- Multi-cycle signed fixed-point divider; the inverse operation to the single-cycle Q-format multiplier in the Math library.
- Computes result = (a << Q_BITS) / b in the same Q format (WIDTH total bits, Q_BITS fractional).
- Uses a radix-2 restoring iteration with a start/valid handshake plus a busy indication.
- Sits beside the multiplier in the shader/raster math datapath; callers handle its longer, fixed latency.

Parameters:
- WIDTH, `WIDTH (global type width, 32), total operand/result width in bits.
- Q_BITS, `Q_BITS (global fraction width, 16), fractional bits; 0 < Q_BITS < WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  signed dividend, Q format.
- b  input  WIDTH  signed divisor, Q format.
- busy  output  1  high while an operation is in flight.
- valid  output  1  one-cycle pulse; result and flags valid this cycle.
- result  output  WIDTH  signed quotient, Q format; held until the next valid.
- div_by_zero  output  1  qualifies valid; b was 0.
- overflow  output  1  qualifies valid; true quotient outside the signed WIDTH range.

Behaviour:
- Reset (rst=1 at edge): state=IDLE; busy=0, valid=0, result=0, div_by_zero=0, overflow=0. Any in-flight operation is aborted with no valid pulse.
- Let N = WIDTH+Q_BITS.
- States:
  - IDLE: busy=0.
  - CALC: busy=1, iteration counter N-1..0.
  - FINISH: busy=1, one cycle.
- IDLE + start=1 at edge 0:
  - Latch sign = a[WIDTH-1]^b[WIDTH-1].
  - Latch dividend = |a| zero-extended to N bits, then << Q_BITS.
  - Latch divisor = |b| as WIDTH-bit unsigned (so |most-negative| = 2^(WIDTH-1) is exact).
  - Clear the partial remainder (WIDTH+1 bits).
  - If b==0, go to FINISH; otherwise go to CALC.
- CALC, each edge: shift the next dividend MSB into the remainder. If remainder >= divisor, subtract and shift quotient bit 1; else shift 0. Exactly N iterations (edges 1..N), then go to FINISH.
- FINISH edge (edge N+1 for normal operation, edge 1 for divide-by-zero):
  - Apply sign (two's-complement negate when sign=1); magnitude truncates toward zero.
  - Register result and flags; valid=1; state goes to IDLE.
- Latency: start edge to valid-high is N+1 cycles (49 for 32/16); divide-by-zero takes 1 cycle.
- valid is high in the cycle the state is IDLE, so busy=0 and a new start in that same cycle is accepted. Back-to-back throughput is one op per N+1 cycles.
- start while busy=1 is ignored (not queued). a and b need only be stable in the start cycle.
- Divide-by-zero: result = 2^(WIDTH-1)-1 if a>=0, else -2^(WIDTH-1); div_by_zero=1, overflow=0.
- Overflow detect: unsigned quotient magnitude > 2^(WIDTH-1)-1 for a positive result, or > 2^(WIDTH-1) for a negative result.
- a = -2^(WIDTH-1), b = -1.0 gives overflow=1.
- Flags are cleared on every valid that does not assert them.

Optional Feature:
- Macro: DIV_SATURATE_EN.
- Defined: on overflow, result saturates to 2^(WIDTH-1)-1 (positive) or -2^(WIDTH-1) (negative); overflow=1.
- Undefined: result is the low WIDTH bits of the signed N-bit quotient (wraps, same truncation style as the multiplier); overflow is still reported.
- Divide-by-zero saturation is unconditional in both builds.

Test Plan (WIDTH=32, Q_BITS=16):
- a=0x00030000 (3.0), b=0x00020000 (2.0), start pulse -> busy for 49 cycles; valid at +49 with result=0x00018000; flags 0.
- a=0xFFFE8000 (-1.5), b=0x00008000 (0.5) -> result=0xFFFD0000 (-3.0). Also a=0x00010000, b=0x00030000 -> 0x00005555 (truncated).
- a=0xFFFF0000, b=0 -> valid at +1, result=0x80000000, div_by_zero=1; then a=0x00010000, b=0 -> result=0x7FFFFFFF.
- a=0x7FFF0000, b=0x00000001 -> overflow=1.
  - DIV_SATURATE_EN defined: result=0x7FFFFFFF.
  - Undefined: result=0x00000000.
- Second start pulsed at +10 while busy -> ignored, only one valid. New start in the valid cycle -> accepted; next valid exactly 49 cycles later.
- rst asserted at +20 of an operation -> next edge busy=0, valid never pulses, outputs 0. A fresh start after reset completes normally.

Source files
------------

// File: rtl/fixed_point_divider.sv
`default_nettype none
// ============================================================================
// Module      : fixed_point_divider
// Description : Multi-cycle signed Q-format divider.
//               Computes result = (a << Q_BITS) / b with a radix-2 restoring
//               iteration. It uses a start/valid handshake and a busy flag.
//               Optional macro DIV_SATURATE_EN: when defined, an overflowing
//               quotient saturates. When undefined, the quotient wraps to its
//               low WIDTH bits. Divide-by-zero saturates in both builds.
// Revision    : 1.0 - initial release
// ============================================================================
module fixed_point_divider #(
  parameter int WIDTH  = 32,
  parameter int Q_BITS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic             div_by_zero_o,
  output logic             overflow_o
);

  // Quotient bits produced. This covers the integer and fraction parts of
  // the pre-shifted dividend.
  localparam int N     = WIDTH + Q_BITS;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CALC   = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  // Largest magnitudes representable for a positive / negative result.
  localparam logic [N-1:0]     POS_LIM = {{(N-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [N-1:0]     NEG_LIM = POS_LIM + N'(1);
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Control state
  logic [1:0]       state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic             sign_q,     sign_d;
  logic             dz_q,       dz_d;

  // Datapath state
  logic [N-1:0]     dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q,  divisor_d;
  logic [WIDTH-1:0] rem_q,      rem_d;
  logic [N-1:0]     quot_q,     quot_d;

  // Output registers
  logic             valid_q,    valid_d;
  logic [WIDTH-1:0] result_q,   result_d;
  logic             dzf_q,      dzf_d;
  logic             ovf_q,      ovf_d;

  // Operand magnitudes. The most negative value maps to 2^(WIDTH-1), which
  // is exact as an unsigned number.
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;

  // Restoring step. The stored remainder is always below the divisor, so
  // WIDTH bits hold it. The shifted working value needs one extra bit.
  logic [WIDTH:0]   w_rem_shift;
  logic             w_rem_ge;
  logic [WIDTH-1:0] w_rem_sub;

  // Finish-stage result formation
  logic             w_ovf;
  logic [WIDTH-1:0] w_mag_low;
  logic [WIDTH-1:0] w_wrapped;
  logic [WIDTH-1:0] w_sat;
  logic [WIDTH-1:0] w_final;

  // Combinational helpers for operand capture and one restoring iteration
  always_comb begin
    w_abs_a     = a_i[WIDTH-1] ? (~a_i + WIDTH'(1)) : a_i;
    w_abs_b     = b_i[WIDTH-1] ? (~b_i + WIDTH'(1)) : b_i;
    w_rem_shift = {rem_q, dividend_q[N-1]};
    w_rem_ge    = (w_rem_shift >= {1'b0, divisor_q});
    // The true difference is below the divisor, so the low WIDTH bits are exact.
    w_rem_sub   = w_rem_shift[WIDTH-1:0] - divisor_q;
  end

  // Sign application, overflow detection and saturation for the finish cycle
  always_comb begin
    w_ovf     = sign_q ? (quot_q > NEG_LIM) : (quot_q > POS_LIM);
    w_mag_low = quot_q[WIDTH-1:0];
    w_wrapped = sign_q ? (~w_mag_low + WIDTH'(1)) : w_mag_low;
    w_sat     = sign_q ? MIN_NEG : MAX_POS;
`ifdef DIV_SATURATE_EN
    w_final   = w_ovf ? w_sat : w_wrapped;
`else
    w_final   = w_wrapped;
`endif
  end

  // Next-state logic: handshake, iteration control and result registration
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sign_d     = sign_q;
    dz_d       = dz_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    valid_d    = 1'b0;
    result_d   = result_q;
    dzf_d      = dzf_q;
    ovf_d      = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          sign_d     = a_i[WIDTH-1] ^ b_i[WIDTH-1];
          dz_d       = (b_i == '0);
          // Zero-extend |a| to N bits and shift it up by Q_BITS.
          dividend_d = {w_abs_a, {Q_BITS{1'b0}}};
          divisor_d  = w_abs_b;
          rem_d      = '0;
          quot_d     = '0;
          cnt_d      = CNT_W'(N - 1);
          state_d    = (b_i == '0) ? S_FINISH : S_CALC;
        end
      end

      S_CALC: begin
        dividend_d = {dividend_q[N-2:0], 1'b0};
        if (w_rem_ge) begin
          rem_d  = w_rem_sub;
          quot_d = {quot_q[N-2:0], 1'b1};
        end else begin
          rem_d  = w_rem_shift[WIDTH-1:0];
          quot_d = {quot_q[N-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = S_FINISH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_FINISH: begin
        valid_d = 1'b1;
        state_d = S_IDLE;
        if (dz_q) begin
          // For b == 0 the latched sign equals the sign of a.
          result_d = w_sat;
          dzf_d    = 1'b1;
          ovf_d    = 1'b0;
        end else begin
          result_d = w_final;
          dzf_d    = 1'b0;
          ovf_d    = w_ovf;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset. Reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      dz_q       <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      valid_q    <= 1'b0;
      result_q   <= '0;
      dzf_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sign_q     <= sign_d;
      dz_q       <= dz_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      valid_q    <= valid_d;
      result_q   <= result_d;
      dzf_q      <= dzf_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy_o        = (state_q != S_IDLE);
  assign valid_o       = valid_q;
  assign result_o      = result_q;
  assign div_by_zero_o = dzf_q;
  assign overflow_o    = ovf_q;

endmodule
`default_nettype wire
